uart_parity: RTL and testbench
==============================

Name: uart_parity

Overview:
- Registered parity generator/checker for the UART datapath, parameterised data width (default 8).
- Produces the parity bit for a data word under the selected parity mode (none, odd, even).
- Also checks a received parity bit against the same word and flags mismatches.
- Sits between the TX/RX shift logic and the frame control FSM.

Parameters:
- DATA_WIDTH, 8, width of data_in in bits (legal range 1..32).

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- data_in  input  DATA_WIDTH  word to generate/check parity over.
- parity_type  input  2  mode, parity_type_t: 00 NOPARITY00, 01 ODD, 10 EVEN, 11 NOPARITY11.
- load  input  1  when high on a rising edge, data_in/parity_type are sampled and outputs update.
- rx_parity  input  1  received parity bit to check; sampled with load.
- parity_bit  output  1  generated parity bit (registered).
- parity_valid  output  1  one-cycle pulse, high the cycle after a load.
- parity_error  output  1  registered mismatch flag for rx_parity vs expected.
- parity_enabled  output  1  registered; 1 when the sampled mode is ODD or EVEN.

Behaviour:
- Reset (reset_n low, asynchronous, immediate):
  - parity_bit=1
  - parity_valid=0
  - parity_error=0
  - parity_enabled=0
- Release is synchronous to the next rising edge; no load is accepted on the release edge unless load is high then.
- On a rising edge with load=1, with x = XOR-reduction of data_in:
  - EVEN (10): parity_bit <= x, so total ones in data+parity is even.
  - ODD (01): parity_bit <= ~x, so total ones is odd.
  - NOPARITY00 / NOPARITY11: parity_bit <= 1 (idle/mark level); parity_enabled <= 0.
  - parity_enabled <= 1 for ODD/EVEN.
  - parity_error <= parity_enabled_next & (rx_parity != expected bit). Always 0 in no-parity modes.
  - parity_valid <= 1.
- With load=0:
  - parity_bit, parity_error and parity_enabled hold.
  - parity_valid <= 0.
- Latency: exactly 1 cycle from load edge to outputs; back-to-back loads each produce results the following cycle, so parity_valid stays high continuously.
- Both no-parity encodings (00 and 11) behave identically.
- Any X on parity_type is treated as a no-parity mode in synthesis; an assertion flags X on parity_type when load=1.
- Reset asserted mid-operation overrides everything immediately and discards any pending load.
- DATA_WIDTH=1: parity_bit = data_in for EVEN, ~data_in for ODD.

Decomposition:
- Package parity_pkg holds:
  - typedef enum logic [1:0] parity_type_t {NOPARITY00, ODD, EVEN, NOPARITY11}
  - function parity_expected(data, mode), used by RTL and scoreboard.
- One combinational sub-module, parity_calc: data + mode -> expected bit and enabled flag.
- The top wraps parity_calc with the registers, valid pulse and error compare.

Test Plan:
- Reset: hold reset_n=0 for 10 ns with load toggling -> parity_bit=1, parity_valid=0, parity_error=0 throughout. Release, load data_in=8'b00010111 NOPARITY00 -> parity_bit=1, parity_enabled=0.
- Even parity:
  - load 8'b10101111 (6 ones) EVEN -> parity_bit=0.
  - load 8'b00000111 (3 ones) EVEN -> parity_bit=1.
  - parity_valid pulses one cycle after each load.
- Odd parity:
  - load 8'b00001111 ODD -> parity_bit=1.
  - load 8'b00000111 ODD -> parity_bit=0.
  - back-to-back loads -> parity_valid held high for 2 cycles.
- No-parity 11: load 8'b10111101 NOPARITY11 with rx_parity=0 -> parity_bit=1, parity_error=0, parity_enabled=0.
- Check path:
  - load 8'b10101001 EVEN with rx_parity=0 -> parity_error=0.
  - same word with rx_parity=1 -> parity_error=1.
  - next cycle load=0 -> error holds, valid drops.
- Async reset mid-stream: assert reset_n between clock edges while parity_bit=0 -> parity_bit goes to 1 immediately, and a load on the same cycle is ignored.

Source files
------------

// File: rtl/parity_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : parity_pkg
//  Brief    : Shared types and the parity rule for the UART parity block.
//  Revision : 1.0  initial release
// ============================================================================
package parity_pkg;

   // Both 00 and 11 select "no parity"; they must behave the same.
   typedef enum logic [1:0] {
      NOPARITY00 = 2'b00,
      ODD        = 2'b01,
      EVEN       = 2'b10,
      NOPARITY11 = 2'b11
   } parity_type_t;

   // Widest data word the block supports; narrower words are zero-extended,
   // which never changes the XOR reduction.
   localparam int c_max_width = 32;

   // Expected parity bit for a word. The default arm also catches an
   // unknown mode, so an X mode resolves to the idle/mark level.
   function automatic logic parity_expected(input logic [c_max_width-1:0] data,
                                            input parity_type_t            mode);
      logic x;
      x = ^data;
      case (mode)
         ODD:     return ~x;
         EVEN:    return x;
         default: return 1'b1;
      endcase
   endfunction

endpackage : parity_pkg
`default_nettype wire

// File: rtl/parity_calc.sv
`default_nettype none
// ============================================================================
//  Module   : parity_calc
//  Brief    : Combinational parity rule: data + mode -> expected bit, enable.
//  Revision : 1.0  initial release
// ============================================================================
module parity_calc
   import parity_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] data,
   input  logic [1:0]            mode,
   output logic                  expected,
   output logic                  enabled
);

   logic [c_max_width-1:0] w_data;
   parity_type_t           w_mode;

   // Zero-extend the word, then apply the mode; unknown modes count as no parity.
   always_comb begin
      w_data                 = '0;
      w_data[DATA_WIDTH-1:0] = data;
      w_mode                 = parity_type_t'(mode);
      expected               = parity_expected(w_data, w_mode);
      case (w_mode)
         ODD, EVEN: enabled = 1'b1;
         default:   enabled = 1'b0;
      endcase
   end

endmodule : parity_calc
`default_nettype wire

// File: rtl/uart_parity.sv
`default_nettype none
// ============================================================================
//  Module   : uart_parity
//  Brief    : Registered parity generator/checker for the UART datapath.
//  Revision : 1.0  initial release
// ============================================================================
module uart_parity
   import parity_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [1:0]            parity_type,
   input  logic                  load,
   input  logic                  rx_parity,
   output logic                  parity_bit,
   output logic                  parity_valid,
   output logic                  parity_error,
   output logic                  parity_enabled
);

   logic w_expected;
   logic w_enabled;
   logic w_error;

   logic r_parity_bit;
   logic r_parity_valid;
   logic r_parity_error;
   logic r_parity_enabled;

   parity_calc #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_calc (
      .data     (data_in),
      .mode     (parity_type),
      .expected (w_expected),
      .enabled  (w_enabled)
   );

   // A mismatch only matters when the new mode actually carries parity.
   always_comb begin
      w_error = w_enabled & (rx_parity != w_expected);
   end

   // Capture results on load; valid is a one-cycle pulse per accepted load.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_parity_bit     <= 1'b1;
         r_parity_valid   <= 1'b0;
         r_parity_error   <= 1'b0;
         r_parity_enabled <= 1'b0;
      end else begin
         r_parity_valid <= load;
         if (load) begin
            r_parity_bit     <= w_expected;
            r_parity_error   <= w_error;
            r_parity_enabled <= w_enabled;
         end
      end
   end

   assign parity_bit     = r_parity_bit;
   assign parity_valid   = r_parity_valid;
   assign parity_error   = r_parity_error;
   assign parity_enabled = r_parity_enabled;

   // An unknown mode on a load would silently fall back to no parity.
   a_mode_known : assert property (@(posedge clock) disable iff (!reset_n)
                                   load |-> !$isunknown(parity_type));

endmodule : uart_parity
`default_nettype wire

// File: tb/tb_uart_parity.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_parity
//  Brief    : Self-checking bench for uart_parity with a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_parity;

   logic       clock        = 1'b0;
   logic       reset_n      = 1'b0;
   logic [7:0] data_in      = '0;
   logic [1:0] parity_type  = 2'b00;
   logic       load         = 1'b0;
   logic       rx_parity    = 1'b0;
   logic       parity_bit;
   logic       parity_valid;
   logic       parity_error;
   logic       parity_enabled;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state: what the outputs should be right now.
   logic m_bit   = 1'b1;
   logic m_valid = 1'b0;
   logic m_err   = 1'b0;
   logic m_en    = 1'b0;

   uart_parity #(.DATA_WIDTH(8)) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .data_in        (data_in),
      .parity_type    (parity_type),
      .load           (load),
      .rx_parity      (rx_parity),
      .parity_bit     (parity_bit),
      .parity_valid   (parity_valid),
      .parity_error   (parity_error),
      .parity_enabled (parity_enabled)
   );

   always #5 clock = ~clock;

   // Parity from counting ones: EVEN makes the total even, ODD makes it odd.
   function automatic logic ref_bit(input logic [7:0] d, input logic [1:0] m);
      int ones;
      ones = $countones(d);
      if (m == 2'b10) return (ones % 2) == 1;
      if (m == 2'b01) return (ones % 2) == 0;
      return 1'b1;
   endfunction

   // Drive one cycle of inputs at the falling edge, advance the model,
   // and return just after the following rising edge.
   task automatic drive(input logic [7:0] d, input logic [1:0] m,
                        input logic rx, input logic ld);
      @(negedge clock);
      data_in     = d;
      parity_type = m;
      rx_parity   = rx;
      load        = ld;
      @(posedge clock);
      #1;
      if (ld) begin
         m_bit = ref_bit(d, m);
         m_en  = (m == 2'b01) || (m == 2'b10);
         m_err = m_en && (rx != m_bit);
      end
      m_valid = ld;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         load = ~load;
         @(posedge clock);
         #1;
         n_tests++;
         if (parity_bit !== 1'b1 || parity_valid !== 1'b0 || parity_error !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: got bit=%b valid=%b err=%b want 1/0/0",
                     parity_bit, parity_valid, parity_error);
         end
      end
      @(negedge clock);
      load    = 1'b0;
      reset_n = 1'b1;
      drive(8'b00010111, 2'b00, 1'b0, 1'b1);
      n_tests++;
      if (parity_bit !== 1'b1 || parity_enabled !== 1'b0 || parity_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_first_load: got bit=%b en=%b valid=%b want 1/0/1",
                  parity_bit, parity_enabled, parity_valid);
      end
   endtask

   task automatic test_even();
      drive(8'b10101111, 2'b10, 1'b0, 1'b1);
      n_tests++;
      if (parity_bit !== 1'b0 || parity_valid !== 1'b1 || parity_enabled !== 1'b1) begin
         n_fail++;
         $display("FAIL even_6ones: got bit=%b valid=%b en=%b want 0/1/1",
                  parity_bit, parity_valid, parity_enabled);
      end
      drive(8'h00, 2'b00, 1'b0, 1'b0);
      n_tests++;
      if (parity_valid !== 1'b0 || parity_bit !== 1'b0) begin
         n_fail++;
         $display("FAIL even_idle: got valid=%b bit=%b want 0/0", parity_valid, parity_bit);
      end
      drive(8'b00000111, 2'b10, 1'b1, 1'b1);
      n_tests++;
      if (parity_bit !== 1'b1 || parity_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL even_3ones: got bit=%b valid=%b want 1/1", parity_bit, parity_valid);
      end
   endtask

   task automatic test_odd();
      drive(8'b00001111, 2'b01, 1'b1, 1'b1);
      n_tests++;
      if (parity_bit !== 1'b1 || parity_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL odd_4ones: got bit=%b valid=%b want 1/1", parity_bit, parity_valid);
      end
      drive(8'b00000111, 2'b01, 1'b0, 1'b1);
      n_tests++;
      if (parity_bit !== 1'b0 || parity_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL odd_back_to_back: got bit=%b valid=%b want 0/1",
                  parity_bit, parity_valid);
      end
      drive(8'h00, 2'b01, 1'b0, 1'b0);
      n_tests++;
      if (parity_valid !== 1'b0 || parity_bit !== 1'b0) begin
         n_fail++;
         $display("FAIL odd_drop: got valid=%b bit=%b want 0/0", parity_valid, parity_bit);
      end
   endtask

   task automatic test_noparity11();
      drive(8'b10111101, 2'b11, 1'b0, 1'b1);
      n_tests++;
      if (parity_bit !== 1'b1 || parity_error !== 1'b0 || parity_enabled !== 1'b0) begin
         n_fail++;
         $display("FAIL noparity11: got bit=%b err=%b en=%b want 1/0/0",
                  parity_bit, parity_error, parity_enabled);
      end
   endtask

   task automatic test_check();
      drive(8'b10101001, 2'b10, 1'b0, 1'b1);
      n_tests++;
      if (parity_error !== 1'b0 || parity_bit !== 1'b0) begin
         n_fail++;
         $display("FAIL check_match: got err=%b bit=%b want 0/0", parity_error, parity_bit);
      end
      drive(8'b10101001, 2'b10, 1'b1, 1'b1);
      n_tests++;
      if (parity_error !== 1'b1) begin
         n_fail++;
         $display("FAIL check_mismatch: got err=%b want 1", parity_error);
      end
      drive(8'hFF, 2'b01, 1'b0, 1'b0);
      n_tests++;
      if (parity_error !== 1'b1 || parity_valid !== 1'b0 || parity_enabled !== 1'b1) begin
         n_fail++;
         $display("FAIL check_hold: got err=%b valid=%b en=%b want 1/0/1",
                  parity_error, parity_valid, parity_enabled);
      end
   endtask

   task automatic test_random();
      logic [7:0] d;
      logic [1:0] m;
      logic       rx;
      logic       ld;
      for (int i = 0; i < 60; i++) begin
         d  = 8'($urandom);
         m  = 2'($urandom);
         rx = 1'($urandom);
         ld = ($urandom_range(0, 3) != 0);
         drive(d, m, rx, ld);
         n_tests++;
         if (parity_bit !== m_bit || parity_valid !== m_valid ||
             parity_error !== m_err || parity_enabled !== m_en) begin
            n_fail++;
            $display("FAIL random[%0d]: got bit=%b valid=%b err=%b en=%b want %b/%b/%b/%b (d=%h m=%b rx=%b ld=%b)",
                     i, parity_bit, parity_valid, parity_error, parity_enabled,
                     m_bit, m_valid, m_err, m_en, d, m, rx, ld);
         end
      end
   endtask

   task automatic test_async_reset();
      drive(8'b10101111, 2'b10, 1'b0, 1'b1);
      n_tests++;
      if (parity_bit !== 1'b0) begin
         n_fail++;
         $display("FAIL async_setup: got bit=%b want 0", parity_bit);
      end
      // Pending load that would also produce 0; reset must discard it.
      @(negedge clock);
      data_in     = 8'b10101111;
      parity_type = 2'b10;
      rx_parity   = 1'b1;
      load        = 1'b1;
      #2;
      reset_n = 1'b0;
      #1;
      n_tests++;
      if (parity_bit !== 1'b1 || parity_valid !== 1'b0 || parity_enabled !== 1'b0) begin
         n_fail++;
         $display("FAIL async_immediate: got bit=%b valid=%b en=%b want 1/0/0",
                  parity_bit, parity_valid, parity_enabled);
      end
      @(posedge clock);
      #1;
      n_tests++;
      if (parity_bit !== 1'b1 || parity_valid !== 1'b0 || parity_error !== 1'b0) begin
         n_fail++;
         $display("FAIL async_load_ignored: got bit=%b valid=%b err=%b want 1/0/0",
                  parity_bit, parity_valid, parity_error);
      end
      m_bit = 1'b1; m_valid = 1'b0; m_err = 1'b0; m_en = 1'b0;
      @(negedge clock);
      load    = 1'b0;
      reset_n = 1'b1;
      drive(8'h00, 2'b00, 1'b0, 1'b0);
      n_tests++;
      if (parity_bit !== 1'b1 || parity_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL async_release: got bit=%b valid=%b want 1/0", parity_bit, parity_valid);
      end
   endtask

   initial begin
      test_reset();
      test_even();
      test_odd();
      test_noparity11();
      test_check();
      test_random();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_uart_parity
`default_nettype wire
